// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: operand width and operation encoding.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath. ADD and SUB share a single 9-bit adder.
module alu_comb
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero,
  output logic              overflow
);

  logic              is_sub;
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   sum;
  logic              add_ovf;

  // Subtraction is a + ~b + 1, so carry-out reads as "no borrow".
  assign is_sub  = (op == OP_SUB);
  assign b_opnd  = is_sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, is_sub};
  assign add_ovf = ~(a[DATA_W-1] ^ b_opnd[DATA_W-1]) & (a[DATA_W-1] ^ sum[DATA_W-1]);

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        overflow  = add_ovf;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu.sv
// 8-bit ALU with one-cycle latency: registers the combinational datapath and a valid strobe.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero,
  output logic              overflow
);

  logic [DATA_W-1:0] result_next;
  logic              carry_next;
  logic              zero_next;
  logic              overflow_next;

  logic [DATA_W-1:0] result_reg;
  logic              carry_reg;
  logic              zero_reg;
  logic              overflow_reg;
  logic              valid_reg;

  alu_comb u_comb (
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result_next),
    .carry_out (carry_next),
    .zero      (zero_next),
    .overflow  (overflow_next)
  );

  // Result and flags load together so a transaction's flags never mix with another's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      zero_reg     <= 1'b1;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        result_reg   <= result_next;
        carry_reg    <= carry_next;
        zero_reg     <= zero_next;
        overflow_reg <= overflow_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign result    = result_reg;
  assign carry_out = carry_reg;
  assign zero      = zero_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors, one line per transaction.
module tb_alu;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_v, input logic [7:0] exp_r,
                         input logic exp_c, input logic exp_z, input logic exp_o);
    chk({tag, ".valid"},    {7'd0, out_valid}, {7'd0, exp_v});
    chk({tag, ".result"},   result,            exp_r);
    chk({tag, ".carry"},    {7'd0, carry_out}, {7'd0, exp_c});
    chk({tag, ".zero"},     {7'd0, zero},      {7'd0, exp_z});
    chk({tag, ".overflow"}, {7'd0, overflow},  {7'd0, exp_o});
    $display("%s: v=%0b a=%02h b=%02h op=%03b -> out_valid=%0b result=%02h c=%0b z=%0b o=%0b",
             tag, in_valid, a, b, op, out_valid, result, carry_out, zero, overflow);
  endtask

  // Present one set of inputs for an edge, then check outputs 1 time unit after it.
  task automatic step(input string tag, input logic v, input logic [7:0] ai, input logic [7:0] bi,
                      input logic [2:0] opi, input logic exp_v, input logic [7:0] exp_r,
                      input logic exp_c, input logic exp_z, input logic exp_o);
    in_valid = v;
    a        = ai;
    b        = bi;
    op       = opi;
    @(posedge clk);
    #1;
    chk_all(tag, exp_v, exp_r, exp_c, exp_z, exp_o);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    op       = 3'b000;
    @(posedge clk);
    #1;
    chk_all("reset_hold", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;

    //      tag          v     a      b      op      ov    res    c     z     o
    step("add_7f_02",  1'b1, 8'h7F, 8'h02, 3'b000, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
    step("add_ff_01",  1'b1, 8'hFF, 8'h01, 3'b000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    step("add_80_80",  1'b1, 8'h80, 8'h80, 3'b000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    step("sub_00_01",  1'b1, 8'h00, 8'h01, 3'b001, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("sub_7f_ff",  1'b1, 8'h7F, 8'hFF, 3'b001, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    step("sub_05_05",  1'b1, 8'h05, 8'h05, 3'b001, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    step("sub_40_10",  1'b1, 8'h40, 8'h10, 3'b001, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
    step("and_11_88",  1'b1, 8'h11, 8'h88, 3'b010, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    step("or_11_88",   1'b1, 8'h11, 8'h88, 3'b011, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step("xor_25_62",  1'b1, 8'h25, 8'h62, 3'b100, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
    step("idle_hold",  1'b0, 8'hFF, 8'h01, 3'b000, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0);
    step("idle_hold2", 1'b0, 8'h7F, 8'h02, 3'b000, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0);
    step("rsvd_111",   1'b1, 8'hFF, 8'hFF, 3'b111, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    step("rsvd_101",   1'b1, 8'h12, 8'h34, 3'b101, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    step("add_7f_02b", 1'b1, 8'h7F, 8'h02, 3'b000, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1);

    // Reset asserted mid-cycle with a live transaction on the inputs.
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFE;
    op       = 3'b011;
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_edge", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;

    step("post_rst_idle", 1'b0, 8'hFF, 8'hFE, 3'b011, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step("post_rst_or",   1'b1, 8'h0F, 8'hF0, 3'b011, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

    // Reset released right before an edge: that first edge must capture.
    #2;
    rst = 1'b1;
    #1;
    in_valid = 1'b1;
    a        = 8'hC0;
    b        = 8'h40;
    op       = 3'b000;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    chk_all("first_edge_add", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    step("after_first", 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
